// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and the
// counter width derivation.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_LCHK = 2'd1,
    S_HIGH = 2'd2,
    S_HCHK = 2'd3
  } state_t;

  // Width able to hold 0..cycles inclusive.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clk domain.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronises and debounces the raw A input; produces a clean level plus
// one-cycle rise/fall pulses for the downstream FSM.
//
//   state  | meaning
//   S_LOW  | a_clean=0, waiting for a high sample
//   S_LCHK | qualifying a candidate 0->1 transition
//   S_HIGH | a_clean=1, waiting for a low sample
//   S_HCHK | qualifying a candidate 1->0 transition
module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic sample_en,
  output logic a_clean,
  output logic a_rise,
  output logic a_fall,
  output logic busy
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             a_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_raw),
    .q   (a_sync)
  );

  // A single-sample debounce commits on the first disagreeing sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sample_en) begin
      case (state)
        S_LOW: begin
          if (a_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = S_HIGH;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = S_LCHK;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        S_LCHK: begin
          if (!a_sync) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!a_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = S_LOW;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = S_HCHK;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        S_HCHK: begin
          if (a_sync) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_clean <= 1'b0;
      a_rise  <= 1'b0;
      a_fall  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      a_clean <= (state_nxt == S_HIGH) || (state_nxt == S_HCHK);
      busy    <= (state_nxt == S_LCHK) || (state_nxt == S_HCHK);
      a_rise  <= rise_nxt;
      a_fall  <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: vector table plus hand-written
// sequences for reset mid-qualification, tick gating and the 1-sample build.
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst, a_raw, sample_en, a_clean, a_rise, a_fall, busy;
  logic a_raw1, en1, c1, r1, f1, b1;

  always #5 clk = ~clk;

  input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .sample_en(sample_en),
    .a_clean(a_clean), .a_rise(a_rise), .a_fall(a_fall), .busy(busy)
  );

  input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .a_raw(a_raw1), .sample_en(en1),
    .a_clean(c1), .a_rise(r1), .a_fall(f1), .busy(b1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // exp packs {a_clean, a_rise, a_fall, busy}
  typedef struct {
    logic       rst;
    logic       raw;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic a, input logic e, input logic [3:0] x);
    vec_t v;
    v.rst = r; v.raw = a; v.en = e; v.exp = x;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: clean/rise/fall/busy got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_raw = 1'b0; sample_en = 1'b1;
    a_raw1 = 1'b0; en1 = 1'b1;

    // Reset held with a_raw=1, then release low.
    for (int i = 0; i < 3; i++) add(1, 1, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    // Clean rise: raw high from row 5, rise pulse 5 edges later.
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b1100);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 4'b1000);
    // Clean fall.
    add(0, 0, 1, 4'b1000);
    add(0, 0, 1, 4'b1000);
    add(0, 0, 1, 4'b1001);
    add(0, 0, 1, 4'b1001);
    add(0, 0, 1, 4'b1001);
    add(0, 0, 1, 4'b0010);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    // Two-cycle glitch rejected.
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 0, 1, 4'b0001);
    add(0, 0, 1, 4'b0001);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    // Three-cycle glitch: one sample short, still rejected.
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0001);
    add(0, 0, 1, 4'b0001);
    add(0, 0, 1, 4'b0001);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; a_raw = tbl[i].raw; sample_en = tbl[i].en;
      step();
      check($sformatf("vec%0d", i), {a_clean, a_rise, a_fall, busy}, tbl[i].exp);
    end

    // Reset asserted while a fall is being qualified.
    rst = 1'b0; a_raw = 1'b1; sample_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (a_rise) break;
    end
    check("setup_rise", {a_clean, a_rise, a_fall, busy}, 4'b1100);
    a_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (busy) break;
    end
    check("hchk_entered", {a_clean, a_rise, a_fall, busy}, 4'b1001);
    rst = 1'b1;
    step();
    check("rst_in_hchk", {a_clean, a_rise, a_fall, busy}, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("post_rst%0d", k), {a_clean, a_rise, a_fall, busy}, 4'b0000);
    end

    // Tick gating: state holds with sample_en low, qualification needs 4 ticks.
    a_raw = 1'b1; sample_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("gated_hold%0d", k), {a_clean, a_rise, a_fall, busy}, 4'b0000);
    end
    for (int k = 0; k < 12; k++) begin
      sample_en = (k % 3 == 0);
      step();
      check($sformatf("tick%0d", k), {a_clean, a_rise, a_fall, busy},
            {k >= 9, k == 9, 1'b0, k < 9});
    end
    sample_en = 1'b1;

    // Single-sample build: a one-cycle raw pulse gives rise then fall.
    for (int k = 0; k < 6; k++) begin
      a_raw1 = (k == 0);
      step();
      check($sformatf("db1_c%0d", k), {c1, r1, f1, b1},
            {k == 2, k == 2, k == 3, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
